rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of write-back requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port hold  input  1  core stall; blocks new grants while high.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-008 SHALL have port req_dest  input  NUM_REQ*ADDRESS_WIDTH  packed destination register, requester i at slice i.
REQ-009 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed write data, requester i at slice i.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 SHALL have port rg_wrt_en  output  1  register-file write enable.
REQ-012 SHALL have port rg_wrt_dest  output  ADDRESS_WIDTH  register-file write address.
REQ-013 SHALL have port rg_wrt_data  output  DATA_WIDTH  register-file write data.
REQ-014 SHALL have port last_grant  output  NUM_REQ  registered one-hot of the most recent accepted requester.

Function
REQ-015 SHALL compute req_ready combinationally in the same cycle as req_valid; at most one bit high.
REQ-016 SHALL drive req_ready to all zeros while hold=1 or rst=1.
REQ-017 SHALL arbitrate round-robin: search starts at pointer ptr and wraps at NUM_REQ-1 to 0.
REQ-018 SHALL set ptr to (i+1) mod NUM_REQ on the edge after a transfer from requester i, and leave ptr unchanged when there is no transfer.
REQ-019 SHALL register the granted dest and data, and assert rg_wrt_en for exactly one cycle in cycle N+1 after a transfer in cycle N (latency 1).
REQ-020 SHALL accept (ready=1) a request with dest 0 but keep rg_wrt_en=0 in the following cycle; last_grant still updates.
REQ-021 SHALL drive rg_wrt_en=0 and hold rg_wrt_dest/rg_wrt_data at their previous values in cycles with no transfer.
REQ-022 SHALL support one write per cycle back-to-back; continuous requests produce rg_wrt_en high every cycle.
REQ-023 SHALL serialise simultaneous requests to the same dest in grant order, so the later grant's data is the final register value.
REQ-024 SHALL let a requester that drops req_valid before grant lose its slot with no transfer and no ptr change.
REQ-025 SHALL produce outputs stable from the rising edge so the register file can capture them on the following falling edge.

Reset
REQ-026 SHALL, on rst=1 at a rising edge: set ptr=0, rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0, last_grant=0.
REQ-027 SHALL discard a transfer that coincides with rst=1; no write is issued after reset deasserts.

Configuration
REQ-028 SHALL, with macro RF_WB_GRANT_CNT_EN defined, add output grant_cnt (NUM_REQ*16 bits, slice i per requester).
REQ-029 SHALL, with RF_WB_GRANT_CNT_EN defined, increment grant_cnt slice i on each transfer from requester i, saturate at 16'hFFFF, and clear it on rst.
REQ-030 SHALL, without RF_WB_GRANT_CNT_EN, have no grant_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: after reset, req_valid=3'b111 held for 3 cycles -> grants 0,1,2 in order; rg_wrt_en high in cycles 2-4 with matching dest/data.
REQ-032 SHALL cover: req 1 writes dest 0, data 32'hDEADBEEF -> req_ready[1]=1, next cycle rg_wrt_en=0, last_grant=3'b010.
REQ-033 SHALL cover: hold=1 with req_valid=3'b101 -> req_ready=0 and rg_wrt_en=0; releasing hold grants req 0 first, then req 2.
REQ-034 SHALL cover: req 0 and req 2 both write dest 5 (data 1 and 2) in the same cycle -> two writes, final value written is 2, ptr=0 afterward.
REQ-035 SHALL cover: rst asserted in the same cycle as a transfer of dest 7 -> no rg_wrt_en after reset, ptr=0.
REQ-036 SHALL cover: with RF_WB_GRANT_CNT_EN, 70000 continuous grants to req 0 only -> grant_cnt slice 0 = 16'hFFFF, other slices 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Round-robin write-back arbiter feeding one register-file write
//            port. Optional per-requester grant counters: RF_WB_GRANT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hold,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]         rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]            rg_wrt_data,
  output logic [NUM_REQ-1:0]               last_grant
`ifdef RF_WB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]            grant_cnt
`endif
);

  localparam int              PTR_W      = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]  C_NUM_REQ  = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(NUM_REQ-1);

  logic [PTR_W-1:0]         r_ptr;
  logic [NUM_REQ-1:0]       w_grant;
  logic [PTR_W-1:0]         w_grant_idx;
  logic                     w_found;
  logic [PTR_W:0]           w_sum;
  logic [PTR_W-1:0]         w_idx;
  logic [NUM_REQ-1:0]       w_ready;
  logic                     w_xfer;
  logic [ADDRESS_WIDTH-1:0] w_dest;
  logic [DATA_WIDTH-1:0]    w_data;

  // Search from r_ptr upward, wrapping; the extra sum bit covers ptr+k < 2*NUM_REQ.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= C_NUM_REQ) begin
        w_sum = w_sum - C_NUM_REQ;
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_idx    = w_idx;
      end
    end
  end

  assign w_ready   = (hold || rst) ? '0 : w_grant;
  assign w_xfer    = |w_ready;
  assign req_ready = w_ready;

  // One-hot select, so OR-ing the masked slices is a plain mux.
  always_comb begin
    w_dest = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dest = w_dest | (req_dest[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] & {ADDRESS_WIDTH{w_ready[i]}});
      w_data = w_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_ready[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
      last_grant  <= '0;
    end else if (w_xfer) begin
      r_ptr       <= (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + 1'b1;
      rg_wrt_en   <= (w_dest != '0);
      rg_wrt_dest <= w_dest;
      rg_wrt_data <= w_data;
      last_grant  <= w_ready;
    end else begin
      rg_wrt_en   <= 1'b0;
    end
  end

`ifdef RF_WB_GRANT_CNT_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_grant_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_ready[i] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign grant_cnt[i*16 +: 16] = r_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Self-checking bench for rf_wb_arbiter (directed + randomized).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [2:0]  req_valid;
  logic [14:0] req_dest;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  logic [2:0]  last_grant;
`ifdef RF_WB_GRANT_CNT_EN
  logic [47:0] grant_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_ptr;
  logic        m_en;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic [2:0]  m_last;
  logic [2:0]  exp_ready;
  int          exp_g;

  rf_wb_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .req_valid   (req_valid),
    .req_dest    (req_dest),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_dest (rg_wrt_dest),
    .rg_wrt_data (rg_wrt_data),
    .last_grant  (last_grant)
`ifdef RF_WB_GRANT_CNT_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Apply inputs and predict the combinational grant from the model pointer.
  task automatic drive(input logic r, input logic h, input logic [2:0] v,
                       input logic [14:0] d, input logic [95:0] dat);
    rst = r; hold = h; req_valid = v; req_dest = d; req_data = dat;
    exp_g = -1;
    for (int k = 0; k < 3; k++) begin
      if (exp_g < 0 && v[(m_ptr + k) % 3]) exp_g = (m_ptr + k) % 3;
    end
    exp_ready = (r || h || exp_g < 0) ? 3'b000 : 3'(1 << exp_g);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_en = 1'b0; m_dest = '0; m_data = '0; m_last = '0;
    end else if (exp_ready != 3'b000) begin
      m_ptr  = (exp_g + 1) % 3;
      m_last = exp_ready;
      m_dest = req_dest[exp_g*5 +: 5];
      m_data = req_data[exp_g*32 +: 32];
      m_en   = (m_dest != 5'd0);
    end else begin
      m_en = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    m_ptr = 0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1});
      n_cmp++;
      if (req_ready !== 3'b000) begin
        n_fail++; $display("FAIL reset_ready c%0d: got %b want 000", c, req_ready);
      end
      tick();
      n_cmp++;
      if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant} !== 41'd0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: got en=%b dest=%0d data=%h last=%b want all 0",
                 c, rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] want [3];
    want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) drive(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
      else       drive(1'b0, 1'b0, 3'b000, '0, '0);
      n_cmp++;
      if (req_ready !== ((c < 3) ? want[c] : 3'b000)) begin
        n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, (c < 3) ? want[c] : 3'b000);
      end
      tick();
      n_cmp++;
      if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant} !== {(c < 3), m_dest, m_data, m_last}) begin
        n_fail++;
        $display("FAIL rr_write c%0d: got en=%b dest=%0d data=%h last=%b want en=%b dest=%0d data=%h last=%b",
                 c, rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant, (c < 3), m_dest, m_data, m_last);
      end
    end
  endtask

  task automatic test_dest_zero();
    drive(1'b0, 1'b0, 3'b010, {5'd9, 5'd0, 5'd9}, {32'h1, 32'hDEADBEEF, 32'h1});
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL dz_ready: got %b want 010", req_ready);
    end
    tick();
    n_cmp++;
    if (rg_wrt_en !== 1'b0 || last_grant !== 3'b010) begin
      n_fail++; $display("FAIL dz_write: got en=%b last=%b want en=0 last=010", rg_wrt_en, last_grant);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 3'b000, '0, '0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 3'b101, {5'd12, 5'd0, 5'd10}, {32'h22, 32'h0, 32'h11});
      n_cmp++;
      if (req_ready !== 3'b000) begin
        n_fail++; $display("FAIL hold_ready c%0d: got %b want 000", c, req_ready);
      end
      tick();
      n_cmp++;
      if (rg_wrt_en !== 1'b0) begin
        n_fail++; $display("FAIL hold_en c%0d: got %b want 0", c, rg_wrt_en);
      end
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 3'b101, {5'd12, 5'd0, 5'd10}, {32'h22, 32'h0, 32'h11});
      n_cmp++;
      if (req_ready !== ((c == 0) ? 3'b001 : 3'b100)) begin
        n_fail++; $display("FAIL release_ready c%0d: got %b want %b", c, req_ready, (c == 0) ? 3'b001 : 3'b100);
      end
      tick();
      n_cmp++;
      if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data} !== {1'b1, (c == 0) ? 5'd10 : 5'd12, (c == 0) ? 32'h11 : 32'h22}) begin
        n_fail++; $display("FAIL release_write c%0d: got en=%b dest=%0d data=%h", c, rg_wrt_en, rg_wrt_dest, rg_wrt_data);
      end
    end
  endtask

  task automatic test_same_dest();
    drive(1'b1, 1'b0, 3'b000, '0, '0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 3'b101, {5'd5, 5'd0, 5'd5}, {32'd2, 32'd0, 32'd1});
      n_cmp++;
      if (req_ready !== ((c == 0) ? 3'b001 : 3'b100)) begin
        n_fail++; $display("FAIL same_ready c%0d: got %b want %b", c, req_ready, (c == 0) ? 3'b001 : 3'b100);
      end
      tick();
      n_cmp++;
      if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data} !== {1'b1, 5'd5, 32'(c + 1)}) begin
        n_fail++; $display("FAIL same_write c%0d: got en=%b dest=%0d data=%0d want en=1 dest=5 data=%0d",
                           c, rg_wrt_en, rg_wrt_dest, rg_wrt_data, c + 1);
      end
    end
    drive(1'b0, 1'b0, 3'b111, {5'd1, 5'd1, 5'd1}, {32'd9, 32'd8, 32'd7});
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL same_ptr: got %b want 001", req_ready);
    end
    tick();
  endtask

  task automatic test_reset_xfer();
    drive(1'b0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd1}, {32'h0, 32'h0, 32'h5});
    tick();
    drive(1'b1, 1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77});
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_fail++; $display("FAIL rstx_ready: got %b want 000", req_ready);
    end
    tick();
    drive(1'b0, 1'b0, 3'b000, '0, '0);
    tick();
    n_cmp++;
    if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant} !== 41'd0) begin
      n_fail++; $display("FAIL rstx_write: got en=%b dest=%0d data=%h last=%b want all 0",
                         rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant);
    end
    drive(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1});
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL rstx_ptr: got %b want 001", req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [14:0] d;
    logic [95:0] dat;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) d[i*5 +: 5] = 5'($urandom_range(0, 6));
      dat = {$urandom, $urandom, $urandom};
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), 3'($urandom), d, dat);
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_ready);
      end
      tick();
      n_cmp++;
      if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant} !== {m_en, m_dest, m_data, m_last}) begin
        n_fail++;
        $display("FAIL rand_write c%0d: got en=%b dest=%0d data=%h last=%b want en=%b dest=%0d data=%h last=%b",
                 c, rg_wrt_en, rg_wrt_dest, rg_wrt_data, last_grant, m_en, m_dest, m_data, m_last);
      end
    end
  endtask

`ifdef RF_WB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    drive(1'b1, 1'b0, 3'b000, '0, '0);
    tick();
    n_cmp++;
    if (grant_cnt !== 48'd0) begin
      n_fail++; $display("FAIL cnt_reset: got %h want 0", grant_cnt);
    end
    drive(1'b0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h4});
    for (int c = 0; c < 70000; c++) tick();
    n_cmp++;
    if (grant_cnt !== {16'h0, 16'h0, 16'hFFFF}) begin
      n_fail++; $display("FAIL cnt_saturate: got %h want 00000000ffff", grant_cnt);
    end
  endtask
`endif

  initial begin
    m_ptr = 0; m_en = 1'b0; m_dest = '0; m_data = '0; m_last = '0;
    test_reset();
    test_round_robin();
    test_dest_zero();
    test_hold();
    test_same_dest();
    test_reset_xfer();
    test_random();
`ifdef RF_WB_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
